// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from the datapath and stage control outputs of pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the stall/flush performance counter signals.
interface pipe_ctrl_if;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned STALL_W   = 32;
    localparam int unsigned FLUSH_W   = 16;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_is_load;
    logic                 ex_bubble;
    logic                 ex_branch_taken;
    logic                 icache_busy;
    logic                 dcache_busy;

    logic                 pc_wr_en;
    logic                 pc_sel_target;
    logic                 if_id_wr_en;
    logic                 id_ex_wr_en;
    logic                 ex_mem_wr_en;
    logic                 mem_wb_wr_en;
    logic                 if_id_gen_bubble;
    logic                 id_ex_gen_bubble;
    logic                 ex_mem_gen_bubble;
    logic                 mem_wb_gen_bubble;
    logic                 flush_if;
`ifdef PIPE_CTRL_PERF_EN
    logic [STALL_W-1:0]   stall_cycles;
    logic [FLUSH_W-1:0]   flush_count;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_bubble,
               ex_branch_taken, icache_busy, dcache_busy,
        input  pc_wr_en, pc_sel_target, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en,
               if_id_gen_bubble, id_ex_gen_bubble, ex_mem_gen_bubble, mem_wb_gen_bubble, flush_if
`ifdef PIPE_CTRL_PERF_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_bubble,
               ex_branch_taken, icache_busy, dcache_busy,
        output pc_wr_en, pc_sel_target, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en,
               if_id_gen_bubble, id_ex_gen_bubble, ex_mem_gen_bubble, mem_wb_gen_bubble, flush_if
`ifdef PIPE_CTRL_PERF_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/bubble controller for a 5-stage in-order pipeline.
// Define PIPE_CTRL_PERF_EN to add saturating stall_cycles / flush_count counters.
module pipe_ctrl (
    input  logic          clk,
    input  logic          reset,
    pipe_ctrl_if.slave    io_pipe
);
    localparam int unsigned HOLD_CNT_W = 2;
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DSTALL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_nxt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    logic w_pc_wr_en;
    logic w_pc_sel_target;
    logic w_if_id_wr_en;
    logic w_id_ex_wr_en;
    logic w_ex_mem_wr_en;
    logic w_mem_wb_wr_en;
    logic w_if_id_gen_bubble;
    logic w_id_ex_gen_bubble;
    logic w_ex_mem_gen_bubble;
    logic w_mem_wb_gen_bubble;
    logic w_flush_if;

    // x0 and an EX bubble can never be the producer of a load-use hazard
    assign w_rs1_hit  = io_pipe.id_use_rs1 && (io_pipe.id_rs1 == io_pipe.ex_rd);
    assign w_rs2_hit  = io_pipe.id_use_rs2 && (io_pipe.id_rs2 == io_pipe.ex_rd);
    assign w_load_use = io_pipe.ex_is_load && !io_pipe.ex_bubble &&
                        (io_pipe.ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Next state and stage controls; a DSTALL cycle with dcache idle behaves as RUN
    always_comb begin
        w_state_nxt         = r_state;
        w_hold_cnt_nxt      = r_hold_cnt;
        w_pc_wr_en          = 1'b0;
        w_pc_sel_target     = 1'b0;
        w_if_id_wr_en       = 1'b1;
        w_id_ex_wr_en       = 1'b1;
        w_ex_mem_wr_en      = 1'b1;
        w_mem_wb_wr_en      = 1'b1;
        w_if_id_gen_bubble  = 1'b1;
        w_id_ex_gen_bubble  = 1'b1;
        w_ex_mem_gen_bubble = 1'b1;
        w_mem_wb_gen_bubble = 1'b1;
        w_flush_if          = 1'b0;

        case (r_state)
            ST_HOLD: begin
                w_hold_cnt_nxt = r_hold_cnt + HOLD_CNT_W'(1);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_RUN, ST_DSTALL: begin
                w_state_nxt         = ST_RUN;
                w_pc_wr_en          = 1'b1;
                w_if_id_gen_bubble  = 1'b0;
                w_id_ex_gen_bubble  = 1'b0;
                w_ex_mem_gen_bubble = 1'b0;
                w_mem_wb_gen_bubble = 1'b0;
                if (io_pipe.dcache_busy) begin
                    // Freeze everything upstream of MEM; branch/load-use re-evaluate later
                    w_state_nxt         = ST_DSTALL;
                    w_pc_wr_en          = 1'b0;
                    w_if_id_wr_en       = 1'b0;
                    w_id_ex_wr_en       = 1'b0;
                    w_ex_mem_wr_en      = 1'b0;
                    w_mem_wb_gen_bubble = 1'b1;
                end else if (io_pipe.ex_branch_taken) begin
                    w_pc_sel_target     = 1'b1;
                    w_if_id_gen_bubble  = 1'b1;
                    w_id_ex_gen_bubble  = 1'b1;
                    w_flush_if          = 1'b1;
                end else if (w_load_use) begin
                    w_pc_wr_en          = 1'b0;
                    w_if_id_wr_en       = 1'b0;
                    w_id_ex_gen_bubble  = 1'b1;
                end else if (io_pipe.icache_busy) begin
                    w_pc_wr_en          = 1'b0;
                    w_if_id_gen_bubble  = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_HOLD;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    assign io_pipe.pc_wr_en          = w_pc_wr_en;
    assign io_pipe.pc_sel_target     = w_pc_sel_target;
    assign io_pipe.if_id_wr_en       = w_if_id_wr_en;
    assign io_pipe.id_ex_wr_en       = w_id_ex_wr_en;
    assign io_pipe.ex_mem_wr_en      = w_ex_mem_wr_en;
    assign io_pipe.mem_wb_wr_en      = w_mem_wb_wr_en;
    assign io_pipe.if_id_gen_bubble  = w_if_id_gen_bubble;
    assign io_pipe.id_ex_gen_bubble  = w_id_ex_gen_bubble;
    assign io_pipe.ex_mem_gen_bubble = w_ex_mem_gen_bubble;
    assign io_pipe.mem_wb_gen_bubble = w_mem_wb_gen_bubble;
    assign io_pipe.flush_if          = w_flush_if;

`ifdef PIPE_CTRL_PERF_EN
    localparam int unsigned STALL_W = 32;
    localparam int unsigned FLUSH_W = 16;

    logic               w_stall_evt;
    logic [STALL_W-1:0] r_stall_cycles;
    logic [FLUSH_W-1:0] r_flush_count;

    assign w_stall_evt = (r_state != ST_HOLD) && !w_pc_wr_en;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + STALL_W'(1);
            end
            if (w_flush_if && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + FLUSH_W'(1);
            end
        end
    end

    assign io_pipe.stall_cycles = r_stall_cycles;
    assign io_pipe.flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, directed multi-cycle sequences and randomized
// stimulus checked against a cycle-level reference model of pipe_ctrl.
module tb_pipe_ctrl;
    logic clk;
    logic reset;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .io_pipe (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_wr, pc_sel, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_gb, id_ex_gb, ex_mem_gb, mem_wb_gb, flush_if}
    localparam logic [10:0] EXP_HOLD    = 11'b00_1111_1111_0;
    localparam logic [10:0] EXP_NORMAL  = 11'b10_1111_0000_0;
    localparam logic [10:0] EXP_DCACHE  = 11'b00_0001_0001_0;
    localparam logic [10:0] EXP_BRANCH  = 11'b11_1111_1100_1;
    localparam logic [10:0] EXP_LOADUSE = 11'b00_0111_0100_0;
    localparam logic [10:0] EXP_ICACHE  = 11'b00_1111_1000_0;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        ld;
        logic        bub;
        logic        br;
        logic        ic;
        logic        dc;
        logic [10:0] exp;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    vec_t        tbl [13];
    vec_t        zero_v;
    int          hold_left;
    int unsigned m_stall;
    logic [15:0] m_flush;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2, input logic [4:0] rd,
                                input logic ld, input logic bub, input logic br,
                                input logic ic, input logic dc, input logic [10:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
        v.ld = ld; v.bub = bub; v.br = br; v.ic = ic; v.dc = dc; v.exp = exp;
        return v;
    endfunction

    function automatic logic [10:0] dut_out();
        return {bus.pc_wr_en, bus.pc_sel_target, bus.if_id_wr_en, bus.id_ex_wr_en,
                bus.ex_mem_wr_en, bus.mem_wb_wr_en, bus.if_id_gen_bubble, bus.id_ex_gen_bubble,
                bus.ex_mem_gen_bubble, bus.mem_wb_gen_bubble, bus.flush_if};
    endfunction

    // Reference: priority of events, ignoring everything while held
    function automatic logic [10:0] model_out(input vec_t v, input int hl, input logic rst);
        logic hazard;
        hazard = v.ld && !v.bub && (v.rd != 5'd0) &&
                 ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        if (!rst || hl > 0) return EXP_HOLD;
        if (v.dc)           return EXP_DCACHE;
        if (v.br)           return EXP_BRANCH;
        if (hazard)         return EXP_LOADUSE;
        if (v.ic)           return EXP_ICACHE;
        return EXP_NORMAL;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_use_rs1      = v.use1;
        bus.id_use_rs2      = v.use2;
        bus.ex_rd           = v.rd;
        bus.ex_is_load      = v.ld;
        bus.ex_bubble       = v.bub;
        bus.ex_branch_taken = v.br;
        bus.icache_busy     = v.ic;
        bus.dcache_busy     = v.dc;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = dut_out();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, got, exp);
        end
    endtask

    // One cycle with reset released: drive at negedge, check before the next posedge
    task automatic apply(input string name, input vec_t v, input logic [10:0] exp);
        @(negedge clk);
        reset = 1'b1;
        drive(v);
        #1;
        check(name, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(zero_v);
        #1;
        check("reset_hold", EXP_HOLD);
    endtask

    initial begin
        vec_t v;
        logic [10:0] e;

        zero_v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NORMAL);
        reset  = 1'b0;
        drive(zero_v);

        tbl[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, EXP_NORMAL);
        tbl[1]  = mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, EXP_LOADUSE);
        tbl[2]  = mk(5'd1, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, 0, EXP_NORMAL);
        tbl[3]  = mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0, 0, EXP_NORMAL);
        tbl[4]  = mk(5'd7, 5'd2, 1, 0, 5'd7, 1, 1, 0, 0, 0, EXP_NORMAL);
        tbl[5]  = mk(5'd7, 5'd2, 1, 0, 5'd7, 0, 0, 0, 0, 0, EXP_NORMAL);
        tbl[6]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, EXP_ICACHE);
        tbl[7]  = mk(5'd3, 5'd4, 1, 1, 5'd3, 1, 0, 1, 1, 0, EXP_BRANCH);
        tbl[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, EXP_DCACHE);
        tbl[9]  = mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 1, EXP_DCACHE);
        tbl[10] = mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 0, EXP_LOADUSE);
        tbl[11] = mk(5'd31, 5'd31, 1, 1, 5'd31, 1, 0, 0, 1, 0, EXP_LOADUSE);
        tbl[12] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, EXP_BRANCH);

        // Reset release: two held cycles, then normal flow
        repeat (2) @(negedge clk);
        do_reset();
        apply("hold_c0", zero_v, EXP_HOLD);
        apply("hold_c1", zero_v, EXP_HOLD);
        apply("run_c2",  zero_v, EXP_NORMAL);

        for (int i = 0; i < 13; i++) begin
            apply($sformatf("vec%0d", i), tbl[i], tbl[i].exp);
        end

        // Load-use inserts exactly one bubble
        v = mk(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, EXP_LOADUSE);
        apply("lu_stall", v, EXP_LOADUSE);
        v.bub = 1'b1;
        apply("lu_after", v, EXP_NORMAL);

        // dcache busy 3 cycles with a pending branch; branch acts on cycle 4
        v = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, EXP_DCACHE);
        for (int i = 0; i < 3; i++) apply($sformatf("dstall%0d", i), v, EXP_DCACHE);
        v.dc = 1'b0;
        apply("dstall_branch", v, EXP_BRANCH);
        apply("dstall_resume", zero_v, EXP_NORMAL);

        // Reset mid-DSTALL takes effect with no clock edge
        v = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, EXP_DCACHE);
        apply("rst_ds0", v, EXP_DCACHE);
        apply("rst_ds1", v, EXP_DCACHE);
        #1 reset = 1'b0;
        #1 check("rst_async", EXP_HOLD);
        @(negedge clk);
        drive(zero_v);
        apply("rst_rel_c0", zero_v, EXP_HOLD);
        apply("rst_rel_c1", zero_v, EXP_HOLD);
        apply("rst_rel_run", zero_v, EXP_NORMAL);

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        n_cmp++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 16'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_count);
        end
        apply("perf_h0", zero_v, EXP_HOLD);
        apply("perf_h1", zero_v, EXP_HOLD);
        v = mk(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, EXP_LOADUSE);
        for (int i = 0; i < 4; i++) begin
            apply("perf_lu", v, EXP_LOADUSE);
            apply("perf_gap", zero_v, EXP_NORMAL);
        end
        v = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, EXP_BRANCH);
        for (int i = 0; i < 2; i++) begin
            apply("perf_br", v, EXP_BRANCH);
            apply("perf_gap", zero_v, EXP_NORMAL);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.stall_cycles !== 32'd4 || bus.flush_count !== 16'd2) begin
            n_err++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d want 4/2",
                     bus.stall_cycles, bus.flush_count);
        end
`endif

        // Randomized run against the reference model
        @(negedge clk);
        reset = 1'b0;
        drive(zero_v);
        hold_left = 2;
        m_stall   = 0;
        m_flush   = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.use1 = 1'($urandom_range(0, 1));
            v.use2 = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.ld   = 1'($urandom_range(0, 1));
            v.bub  = ($urandom_range(0, 3) == 0);
            v.br   = ($urandom_range(0, 7) == 0);
            v.ic   = ($urandom_range(0, 3) == 0);
            v.dc   = ($urandom_range(0, 5) == 0);
            reset  = ($urandom_range(0, 49) != 0);
            drive(v);
            #1;
            e = model_out(v, hold_left, reset);
            check("rand", e);
`ifdef PIPE_CTRL_PERF_EN
            n_cmp++;
            if (bus.stall_cycles !== m_stall || bus.flush_count !== m_flush) begin
                n_err++;
                $display("FAIL rand_perf @%0t: got %0d/%0d want %0d/%0d", $time,
                         bus.stall_cycles, bus.flush_count, m_stall, m_flush);
            end
`endif
            if (!reset) begin
                hold_left = 2;
                m_stall   = 0;
                m_flush   = '0;
            end else if (hold_left > 0) begin
                hold_left--;
            end else begin
                if (!e[10]) m_stall++;
                if (e[0])   m_flush++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
